muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit beside the single-cycle ALU, fed the same a/b operands from the register file.
//  It executes MULT/MULTU/DIV/DIVU over multiple cycles into the HI/LO register pair, and performs MTHI/MTLO writes.
//  It drives hi/lo to the writeback mux for MFHI/MFLO. Control stalls the pipeline while busy is high.
// PARAMETERS
//  WIDTH   32   operand width; hi and lo are each WIDTH bits
//  CNT_W   5    iteration counter width, must equal clog2(WIDTH)
// PORTS
//  clk     in   1      rising-edge clock, the only clock
//  rst_n   in   1      asynchronous active-low reset
//  start   in   1      request; sampled only when busy==0
//  op      in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op
//  a       in   WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO data
//  b       in   WIDTH  rt operand: multiplier or divisor
//  flush   in   1      synchronous abort of an in-flight operation
//  busy    out  1      operation in flight; HI/LO not yet valid
//  done    out  1      one-cycle pulse in the cycle HI/LO take the new result
//  hi      out  WIDTH  HI register
//  lo      out  WIDTH  LO register
// BEHAVIOUR
//  Reset (rst_n=0, async, any state): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, internal regs=0.
//  States: IDLE, MUL, DIV, FIN.
//  IDLE, start=1:
//   op MULT/MULTU: latch operands; counter=0; next state MUL; busy=1 from the next cycle.
//   op DIV/DIVU: latch operands; counter=0; next state DIV; busy=1 from the next cycle.
//   op MTHI: hi<=a next edge, lo unchanged, busy stays 0, no done pulse.
//   op MTLO: lo<=a next edge, hi unchanged, busy stays 0, no done pulse.
//   op 110/111: ignored, no state change.
//  Operand conditioning for signed ops (MULT/DIV): latch |a|, |b| and the sign flags.
//   |x| of 0x8000_0000 is 0x8000_0000 taken as unsigned.
//  MUL: shift-add, one multiplier bit per cycle, WIDTH cycles (counter 0..WIDTH-1), then FIN.
//   Accumulator is 2*WIDTH bits; no overflow is possible.
//  DIV: restoring division, one quotient bit per cycle, WIDTH cycles, then FIN.
//  FIN (one cycle): apply sign correction; write hi/lo; done=1; busy=0 in the following cycle; next state IDLE.
//   Signed quotient is negative iff the operand signs differ; the remainder takes the sign of the dividend.
//  Latency: start accepted at edge N -> busy=1 for cycles N+1..N+WIDTH+1; done=1 and hi/lo valid at N+WIDTH+1;
//   a new start is accepted at edge N+WIDTH+2 at the earliest.
//  Results:
//   MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product.
//   DIV/DIVU: lo = quotient, hi = remainder.
//  hi/lo hold their old values throughout MUL/DIV; they change only in FIN, on MTHI/MTLO, or on reset.
//  Divide by zero (b==0, signed or unsigned): same latency; lo = all ones, hi = a (original, unconditioned).
//  Signed overflow 0x8000_0000 / 0xFFFF_FFFF: lo = 0x8000_0000, hi = 0; no trap.
//  start while busy=1: ignored, with no effect on the in-flight operation.
//  flush=1 in MUL/DIV/FIN: next state IDLE, busy=0, no done pulse, hi/lo keep their pre-op values.
//   flush has priority over FIN completion. In IDLE, flush has priority over start (start is dropped).
//  Operands a/b may change freely after the accept edge; only latched copies are used.
// TESTING
//  1. Reset: assert rst_n=0 mid-DIV -> busy=0, done=0, hi=lo=0 immediately, without waiting for a clock edge.
//  2. MULTU a=0xFFFF_FFFF, b=0xFFFF_FFFF -> done at start+33 edges; hi=0xFFFF_FFFE, lo=0x0000_0001.
//  3. MULT a=-7 (0xFFFF_FFF9), b=3 -> hi=0xFFFF_FFFF, lo=0xFFFF_FFEB.
//     Check busy is high for exactly 33 cycles and a start issued mid-op is ignored.
//  4. DIV a=-7, b=2 -> lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1).
//     DIVU a=100, b=7 -> lo=14, hi=2.
//  5. DIV a=0x8000_0000, b=0xFFFF_FFFF -> lo=0x8000_0000, hi=0.
//     DIVU a=0x1234, b=0 -> lo=0xFFFF_FFFF, hi=0x1234.
//  6. MTHI a=0xDEAD_BEEF, then MTLO a=0x1 -> hi/lo update one edge each, busy stays 0.
//     Then start MULT and flush at cycle 10 -> no done pulse, hi=0xDEAD_BEEF and lo=0x1 retained.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, plus direct MTHI/MTLO writes.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic                 neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic                 is_div_q, is_div_d;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic                 done_q, done_d;

    logic                 signed_op, a_neg, b_neg;
    logic [WIDTH-1:0]     a_abs, b_abs;
    logic [WIDTH:0]       mul_sum, div_shift;
    logic [WIDTH-1:0]     div_rem;
    logic                 div_ge, last_iter;
    logic [2*WIDTH-1:0]   fin_prod;
    logic [WIDTH-1:0]     fin_quo, fin_rem, a_orig;

    // Datapath: operand conditioning, one iteration step and final sign fix-up.
    always_comb begin
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        a_neg     = signed_op && a[WIDTH-1];
        b_neg     = signed_op && b[WIDTH-1];
        a_abs     = a_neg ? -a : a;
        b_abs     = b_neg ? -b : b;

        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_ge    = div_shift >= {1'b0, b_q};
        div_rem   = div_shift[WIDTH-1:0] - b_q;
        last_iter = (cnt_q == CNT_W'(WIDTH-1));

        fin_prod  = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
        fin_quo   = (neg_a_q ^ neg_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        fin_rem   = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        a_orig    = neg_a_q ? -a_q : a_q;
    end

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path infers a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        a_d      = a_q;
        b_d      = b_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        is_div_d = is_div_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    unique case (op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            a_d      = a_abs;
                            b_d      = b_abs;
                            neg_a_d  = a_neg;
                            neg_b_d  = b_neg;
                            cnt_d    = '0;
                            is_div_d = op[1];
                            acc_d    = op[1] ? {{WIDTH{1'b0}}, a_abs} : {{WIDTH{1'b0}}, b_abs};
                            state_d  = op[1] ? S_DIV : S_MUL;
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            S_MUL, S_DIV: begin
                if (flush) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    if (state_q == S_MUL)
                        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    else if (div_ge)
                        acc_d = {div_rem, acc_q[WIDTH-2:0], 1'b1};
                    else
                        acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
                    cnt_d = last_iter ? '0 : cnt_q + 1'b1;
                    if (last_iter)
                        state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (!is_div_q) begin
                        {hi_d, lo_d} = fin_prod;
                    end else if (b_q == '0) begin
                        // Divide by zero returns all-ones quotient and the untouched dividend.
                        lo_d = '1;
                        hi_d = a_orig;
                    end else begin
                        lo_d = fin_quo;
                        hi_d = fin_rem;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            is_div_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            is_div_q <= is_div_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
